instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 21-bit RISC core. It owns the 8-bit program counter, drives the instruction-ROM address and latches the returned opcode/rs/rt/rd/imm fields into an instruction register. It sequences register-file and ALU control strobes and resolves jumps and branches. It sits between the instruction ROM, the register file and the ALU.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/instr_sequencer_if.sv | 32 +++
 rtl/pc_unit.sv | 17 +
 rtl/instr_sequencer.sv | 98 +++++++++
 tb/tb_instr_sequencer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, field widths, sequencer states and PC select shared by the 21-bit core
package cpu_pkg;
  localparam int OP_W  = 4;
  localparam int REG_W = 3;
  localparam int IMM_W = 8;
  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [OP_W-1:0] OP_OR   = 4'h4;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h5;
  localparam logic [OP_W-1:0] OP_LI   = 4'h6;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h7;
  localparam logic [OP_W-1:0] OP_BNE  = 4'h8;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;
  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_LOAD} pc_sel_t;
  function automatic logic writes_reg(input logic [OP_W-1:0] op);
    return op >= OP_ADD && op <= OP_LI;
  endfunction
  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op >= 4'hA && op <= 4'hE;
  endfunction
  function automatic logic branch_taken(input logic [OP_W-1:0] op, input logic zero);
    return op == OP_JMP || (op == OP_BEQ && zero) || (op == OP_BNE && !zero);
  endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: ROM, ALU/register-file and status signals of the sequencer
interface instr_sequencer_if import cpu_pkg::*; #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             Run;
  logic [PC_W-1:0]  Addr;
  logic [OP_W-1:0]  DataOp;
  logic [REG_W-1:0] Datars;
  logic [REG_W-1:0] Datart;
  logic [REG_W-1:0] Datard;
  logic [IMM_W-1:0] Datai;
  logic             Zero;
  logic [OP_W-1:0]  IrOp;
  logic [REG_W-1:0] IrRs;
  logic [REG_W-1:0] IrRt;
  logic [REG_W-1:0] IrRd;
  logic [IMM_W-1:0] IrImm;
  logic             ImmSel;
  logic             RegWrite;
  logic             Halted;
  logic             Illegal;
  logic [CNT_W-1:0] InstrCount;
  modport master (
    input  Run, DataOp, Datars, Datart, Datard, Datai, Zero,
    output Addr, IrOp, IrRs, IrRt, IrRd, IrImm, ImmSel, RegWrite, Halted, Illegal, InstrCount
  );
  modport slave (
    output Run, DataOp, Datars, Datart, Datard, Datai, Zero,
    input  Addr, IrOp, IrRs, IrRt, IrRd, IrImm, ImmSel, RegWrite, Halted, Illegal, InstrCount
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter register with hold / increment / load-immediate selection
module pc_unit import cpu_pkg::*; #(
  parameter int PC_W = 8
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  pc_sel_t         sel,
  input  logic [PC_W-1:0] imm,
  output logic [PC_W-1:0] pc
);
  logic [PC_W-1:0] pc_q, pc_d;
  always_comb pc_d = sel == PC_LOAD ? imm : sel == PC_INC ? pc_q + PC_W'(1) : pc_q;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) pc_q <= '0;
    else pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/writeback controller for the 21-bit core
module instr_sequencer import cpu_pkg::*; #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input logic              Clk,
  input logic              Rst_n,
  instr_sequencer_if.master bus
);
  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [REG_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pc_sel_t          pc_sel;
  logic [PC_W-1:0]  pc;
  pc_unit #(.PC_W(PC_W)) u_pc (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .sel   (pc_sel),
    .imm   (PC_W'(imm_q)),
    .pc    (pc)
  );
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    pc_sel    = PC_HOLD;
    case (state_q)
      S_IDLE:    state_d = bus.Run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        op_d    = bus.DataOp;
        rs_d    = bus.Datars;
        rt_d    = bus.Datart;
        rd_d    = bus.Datard;
        imm_d   = bus.Datai;
        state_d = S_DECODE;
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (op_q == OP_HALT) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_HALT;
        end else if (writes_reg(op_q)) begin
          state_d = S_WRITEBACK;
        end else begin
          pc_sel    = branch_taken(op_q, bus.Zero) ? PC_LOAD : PC_INC;
          cnt_d     = cnt_q + CNT_W'(1);
          illegal_d = illegal_q | is_illegal(op_q);
          state_d   = bus.Run ? S_FETCH : S_IDLE;
        end
      end
      S_WRITEBACK: begin
        pc_sel  = PC_INC;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = bus.Run ? S_FETCH : S_IDLE;
      end
      default:   state_d = S_HALT;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  assign bus.Addr       = pc;
  assign bus.IrOp       = op_q;
  assign bus.IrRs       = rs_q;
  assign bus.IrRt       = rt_q;
  assign bus.IrRd       = rd_q;
  assign bus.IrImm      = imm_q;
  assign bus.ImmSel     = op_q == OP_ADDI || op_q == OP_LI;
  assign bus.RegWrite   = state_q == S_WRITEBACK;
  assign bus.Halted     = state_q == S_HALT;
  assign bus.Illegal    = illegal_q;
  assign bus.InstrCount = cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: instruction-level reference model driving a ROM image against instr_sequencer
module tb_instr_sequencer;
  import cpu_pkg::*;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;
  instr_sequencer_if bus ();
  instr_sequencer dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
  logic [20:0] rom [256];
  logic        zero_tbl [256];
  assign bus.DataOp = rom[bus.Addr][20:17];
  assign bus.Datars = rom[bus.Addr][16:14];
  assign bus.Datart = rom[bus.Addr][13:11];
  assign bus.Datard = rom[bus.Addr][10:8];
  assign bus.Datai  = rom[bus.Addr][7:0];
  assign bus.Zero   = zero_tbl[bus.Addr];
  int vectors = 0;
  int errors = 0;
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;
  logic        m_ill;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [20:0] ins(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                                      input logic [2:0] rd, input logic [7:0] imm);
    return {op, rs, rt, rd, imm};
  endfunction
  function automatic logic [7:0] next_pc(input logic [3:0] op, input logic [7:0] imm, input logic z,
                                         input logic [7:0] pc);
    case (op)
      OP_HALT: return pc;
      OP_JMP:  return imm;
      OP_BEQ:  return z ? imm : pc + 8'd1;
      OP_BNE:  return z ? pc + 8'd1 : imm;
      default: return pc + 8'd1;
    endcase
  endfunction
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic do_reset();
    Rst_n = 1'b0;
    bus.Run = 1'b0;
    #2;
    check("rst_addr", bus.Addr, 0);
    check("rst_irop", bus.IrOp, 0);
    check("rst_irimm", bus.IrImm, 0);
    check("rst_regwrite", bus.RegWrite, 0);
    check("rst_halted", bus.Halted, 0);
    check("rst_illegal", bus.Illegal, 0);
    check("rst_count", bus.InstrCount, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    m_pc = 8'd0;
    m_cnt = 16'd0;
    m_ill = 1'b0;
  endtask
  task automatic start();
    bus.Run = 1'b1;
    step();
  endtask
  task automatic run_instr(input bit drop_run);
    logic [20:0] w;
    logic [3:0]  op;
    bit          wb;
    w  = rom[m_pc];
    op = w[20:17];
    wb = op >= 4'd1 && op <= 4'd6;
    check("fetch_addr", bus.Addr, m_pc);
    step();
    check("irop", bus.IrOp, op);
    check("irrs", bus.IrRs, w[16:14]);
    check("irrd", bus.IrRd, w[10:8]);
    check("irimm", bus.IrImm, w[7:0]);
    check("immsel", bus.ImmSel, op == 4'd5 || op == 4'd6);
    if (drop_run) bus.Run = 1'b0;
    step();
    check("regwrite_exec", bus.RegWrite, 0);
    step();
    if (wb) begin
      check("regwrite_wb", bus.RegWrite, 1);
      step();
    end
    m_pc  = next_pc(op, w[7:0], zero_tbl[m_pc], m_pc);
    m_cnt = m_cnt + 16'd1;
    m_ill = m_ill | (op >= 4'hA && op <= 4'hE);
    check("regwrite_after", bus.RegWrite, 0);
    check("next_addr", bus.Addr, m_pc);
    check("count", bus.InstrCount, m_cnt);
    check("illegal", bus.Illegal, m_ill);
    check("halted", bus.Halted, op == 4'hF);
    if (drop_run) begin
      repeat (3) step();
      check("park_addr", bus.Addr, m_pc);
      check("park_count", bus.InstrCount, m_cnt);
      check("park_regwrite", bus.RegWrite, 0);
      bus.Run = 1'b1;
      step();
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = '0;
      zero_tbl[i] = 1'b0;
    end
    rom[8'h00] = ins(OP_ADD, 3'd2, 3'd3, 3'd1, 8'h00);
    rom[8'h01] = ins(OP_JMP, 3'd0, 3'd0, 3'd0, 8'h05);
    rom[8'h05] = ins(OP_BEQ, 3'd1, 3'd1, 3'd0, 8'h20);
    rom[8'h20] = ins(OP_JMP, 3'd0, 3'd0, 3'd0, 8'h05);
    rom[8'h06] = ins(OP_JMP, 3'd0, 3'd0, 3'd0, 8'hFF);
    rom[8'h02] = ins(4'hB, 3'd4, 3'd5, 3'd6, 8'h77);
    rom[8'h03] = ins(OP_JMP, 3'd0, 3'd0, 3'd0, 8'h07);
    rom[8'h07] = ins(OP_ADDI, 3'd1, 3'd0, 3'd4, 8'h11);
    rom[8'h08] = ins(OP_LI, 3'd0, 3'd0, 3'd5, 8'h42);
    rom[8'h09] = ins(OP_BNE, 3'd2, 3'd3, 3'd0, 8'h30);
    zero_tbl[8'h05] = 1'b1;
    do_reset();
    start();
    run_instr(0);
    check("add_addr", bus.Addr, 1);
    check("add_count", bus.InstrCount, 1);
    run_instr(0);
    run_instr(0);
    check("beq_taken", bus.Addr, 8'h20);
    run_instr(0);
    zero_tbl[8'h05] = 1'b0;
    run_instr(0);
    check("beq_not_taken", bus.Addr, 8'h06);
    run_instr(0);
    rom[8'h00] = ins(OP_JMP, 3'd0, 3'd0, 3'd0, 8'h02);
    run_instr(0);
    check("pc_wrap", bus.Addr, 8'h00);
    run_instr(0);
    run_instr(0);
    check("illegal_set", bus.Illegal, 1);
    check("illegal_next", bus.Addr, 8'h03);
    run_instr(0);
    run_instr(1);
    check("resume_addr", bus.Addr, 8'h08);
    run_instr(0);
    run_instr(0);
    run_instr(0);
    rom[m_pc] = ins(OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00);
    check("abort_fetch", bus.Addr, m_pc);
    repeat (3) step();
    check("abort_in_wb", bus.RegWrite, 1);
    #2 Rst_n = 1'b0;
    #1;
    check("abort_regwrite", bus.RegWrite, 0);
    check("abort_count", bus.InstrCount, 0);
    check("abort_addr", bus.Addr, 0);
    for (int i = 0; i < 256; i++) begin
      rom[i] = {4'($urandom_range(0, 14)), 17'($urandom)};
      zero_tbl[i] = 1'($urandom);
    end
    do_reset();
    start();
    repeat (200) run_instr($urandom_range(0, 7) == 0);
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[8'h03] = ins(OP_HALT, 3'd0, 3'd0, 3'd0, 8'h00);
    do_reset();
    start();
    repeat (4) run_instr(0);
    check("halt_count", bus.InstrCount, 4);
    for (int i = 0; i < 20; i++) begin
      step();
      check("halt_addr", bus.Addr, 3);
      check("halt_flag", bus.Halted, 1);
    end
    check("halt_count_hold", bus.InstrCount, 4);
    #2 Rst_n = 1'b0;
    #1;
    check("async_halted", bus.Halted, 0);
    check("async_addr", bus.Addr, 0);
    check("async_count", bus.InstrCount, 0);
    Rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
